// File: rtl/fp_mul_pkg.sv
// Shared definitions for the pipelined floating-point multiplier:
// rounding-mode encodings, exception flag bundle and field helpers.
package fp_mul_pkg;

  localparam logic RND_HALF_UP      = 1'b0;
  localparam logic RND_NEAREST_EVEN = 1'b1;

  typedef struct packed {
    logic inv;
    logic ovf;
    logic unf;
  } fp_flags_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Field extractors work on a word zero-extended to 64 bits so one helper
  // serves every EXP_W/MAN_W combination; callers cast back to field width.
  function automatic logic fp_sign_bit(input logic [63:0] x, input int exp_w,
                                       input int man_w);
    return x[exp_w + man_w];
  endfunction

  function automatic logic [63:0] fp_exp_field(input logic [63:0] x,
                                               input int exp_w,
                                               input int man_w);
    return (x >> man_w) & ((64'd1 << exp_w) - 64'd1);
  endfunction

  function automatic logic [63:0] fp_frac_field(input logic [63:0] x,
                                                input int man_w);
    return x & ((64'd1 << man_w) - 64'd1);
  endfunction

endpackage

// File: rtl/fp_mul_pipe_round_norm.sv
// Combinational normalise + round + renormalise of a raw significand product.
// Returns the stored fraction and the exponent after both adjustments.
module fp_round_norm
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [2*MAN_W+1:0]      prod_i,
  input  logic signed [EXP_W+1:0] exp_i,
  input  logic                    rnd_mode_i,
  output logic [MAN_W-1:0]        frac_o,
  output logic signed [EXP_W+1:0] exp_o
);

  localparam int M  = MAN_W;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] ONE_S = EW'(1);

  function automatic logic round_inc(input logic mode, input logic g,
                                     input logic s, input logic lsb);
    if (mode == RND_NEAREST_EVEN) return g & (s | lsb);
    return g;
  endfunction

  logic [M:0]             kept;
  logic                   guard;
  logic                   sticky;
  logic signed [EW-1:0]   exp_n;
  logic [M+1:0]           rsum;

  always_comb begin
    // Product in [1,4): a set top bit means one extra right shift, and the
    // bit that falls off joins the sticky group.
    if (prod_i[2*M+1]) begin
      kept   = prod_i[2*M+1:M+1];
      guard  = prod_i[M];
      sticky = |prod_i[M-1:0];
      exp_n  = exp_i + ONE_S;
    end else begin
      kept   = prod_i[2*M:M];
      guard  = prod_i[M-1];
      sticky = |prod_i[M-2:0];
      exp_n  = exp_i;
    end

    rsum = {1'b0, kept} + (M+2)'(round_inc(rnd_mode_i, guard, sticky, kept[0]));

    // Rounding carry out of 1.111..1 gives exactly 2.0; renormalise.
    if (rsum[M+1]) begin
      frac_o = rsum[M:1];
      exp_o  = exp_n + ONE_S;
    end else begin
      frac_o = rsum[M-1:0];
      exp_o  = exp_n;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier with valid/ready flow control,
// selectable rounding and separate invalid/overflow/underflow flags.
module fp_mul_pipe
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         rnd_mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] c,
  output logic         ovf,
  output logic         unf,
  output logic         inv
);

  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [EW-1:0] BIAS_S = EW'(fp_bias(EXP_W));
  localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ZERO_S = EW'(0);
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic [EXP_W-1:0]     EXP_ZERO = '0;

  logic      en;
  logic      vld_p1, vld_p2, out_valid_q;
  logic [W-1:0] c_q, c_d;
  fp_flags_t flags_q, flags_d;

  // Whole pipeline advances together; it freezes only when a result waits.
  assign en       = !out_valid_q | out_ready;
  assign in_ready = en;

  // ---- stage 0 -> 1: unpack, sign, exponent sum, significand product ----
  logic                 sa_p0, sb_p0;
  logic [EXP_W-1:0]     ea_p0, eb_p0;
  logic [MAN_W-1:0]     fa_p0, fb_p0;
  logic signed [EW-1:0] exp_p0;
  logic [PW-1:0]        prod_p0;

  always_comb begin
    sa_p0   = fp_sign_bit(64'(a), EXP_W, MAN_W);
    sb_p0   = fp_sign_bit(64'(b), EXP_W, MAN_W);
    ea_p0   = EXP_W'(fp_exp_field(64'(a), EXP_W, MAN_W));
    eb_p0   = EXP_W'(fp_exp_field(64'(b), EXP_W, MAN_W));
    fa_p0   = MAN_W'(fp_frac_field(64'(a), MAN_W));
    fb_p0   = MAN_W'(fp_frac_field(64'(b), MAN_W));
    exp_p0  = $signed({2'b00, ea_p0}) + $signed({2'b00, eb_p0}) - BIAS_S;
    prod_p0 = PW'({1'b1, fa_p0}) * PW'({1'b1, fb_p0});
  end

  logic                 sign_p1, rnd_p1, inv_p1, zero_p1;
  logic signed [EW-1:0] exp_p1;
  logic [PW-1:0]        prod_p1;

  always_ff @(posedge clk) begin
    if (en) begin
      sign_p1 <= sa_p0 ^ sb_p0;
      rnd_p1  <= rnd_mode;
      inv_p1  <= (ea_p0 == EXP_ONES) | (eb_p0 == EXP_ONES);
      zero_p1 <= (ea_p0 == EXP_ZERO) | (eb_p0 == EXP_ZERO);
      exp_p1  <= exp_p0;
      prod_p1 <= prod_p0;
    end
  end

  // ---- stage 1 -> 2: normalise and round ----
  logic [MAN_W-1:0]     frac_rn;
  logic signed [EW-1:0] exp_rn;

  fp_round_norm #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_norm (
    .prod_i     (prod_p1),
    .exp_i      (exp_p1),
    .rnd_mode_i (rnd_p1),
    .frac_o     (frac_rn),
    .exp_o      (exp_rn)
  );

  logic                 sign_p2, inv_p2, zero_p2;
  logic signed [EW-1:0] exp_p2;
  logic [MAN_W-1:0]     frac_p2;

  always_ff @(posedge clk) begin
    if (en) begin
      sign_p2 <= sign_p1;
      inv_p2  <= inv_p1;
      zero_p2 <= zero_p1;
      exp_p2  <= exp_rn;
      frac_p2 <= frac_rn;
    end
  end

  // ---- stage 2 -> 3: exception priority, pack, flags ----
  always_comb begin
    c_d     = {sign_p2, exp_p2[EXP_W-1:0], frac_p2};
    flags_d = '0;
    if (inv_p2) begin
      c_d         = '1;
      flags_d.inv = 1'b1;
    end else if (zero_p2) begin
      c_d = {sign_p2, {(W-1){1'b0}}};
    end else if (exp_p2 >= EMAX_S) begin
      c_d         = '1;
      flags_d.ovf = 1'b1;
    end else if (exp_p2 <= ZERO_S) begin
      c_d         = {sign_p2, {(W-1){1'b0}}};
      flags_d.unf = 1'b1;
    end
  end

  // Control and the visible result are reset; interior data is not.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      flags_q     <= '0;
    end else if (en) begin
      vld_p1      <= in_valid;
      vld_p2      <= vld_p1;
      out_valid_q <= vld_p2;
      if (vld_p2) begin
        c_q     <= c_d;
        flags_q <= flags_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign inv       = flags_q.inv;
  assign ovf       = flags_q.ovf;
  assign unf       = flags_q.unf;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: directed vectors, flow-control sequences and
// randomized traffic scored against an arithmetic reference model.
module tb_fp_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready, rnd_mode, out_valid, out_ready;
  logic        ovf, unf, inv;
  logic [31:0] a, b, c;

  logic        iv16, ir16, rm16, ov16, or16, ovf16, unf16, inv16;
  logic [15:0] a16, b16, c16;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rnd_mode(rnd_mode), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .c(c), .ovf(ovf), .unf(unf), .inv(inv));

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16),
    .rnd_mode(rm16), .a(a16), .b(b16), .out_valid(ov16),
    .out_ready(or16), .c(c16), .ovf(ovf16), .unf(unf16), .inv(inv16));

  typedef struct packed {
    logic [63:0] c;
    logic        inv;
    logic        ovf;
    logic        unf;
  } res_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int n_out = 0;
  res_t exp_q[$];
  res_t mres;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact integer product, rounded by remainder comparison.
  function automatic res_t ref_mul(input longint unsigned xa, input longint unsigned xb,
                                   input int ew, input int mw, input logic rm);
    res_t r;
    longint unsigned emax, ones, ea, eb, ma, mb, p, q, rem, half;
    longint e;
    int w, bias, sh;
    logic s;
    w    = 1 + ew + mw;
    bias = (1 << (ew - 1)) - 1;
    emax = (64'd1 << ew) - 1;
    ones = (64'd1 << w) - 1;
    s    = xa[w-1] ^ xb[w-1];
    ea   = (xa >> mw) & emax;
    eb   = (xb >> mw) & emax;
    r    = '0;
    if (ea == emax || eb == emax) begin
      r.c = ones; r.inv = 1'b1; return r;
    end
    if (ea == 0 || eb == 0) begin
      r.c = 64'(s) << (w - 1); return r;
    end
    ma = (xa & ((64'd1 << mw) - 1)) | (64'd1 << mw);
    mb = (xb & ((64'd1 << mw) - 1)) | (64'd1 << mw);
    p  = ma * mb;
    e  = longint'(ea) + longint'(eb) - longint'(bias);
    sh = mw;
    if (p >= (64'd1 << (2 * mw + 1))) begin sh = mw + 1; e = e + 1; end
    q    = p >> sh;
    rem  = p & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    if (rm) begin
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end else if (rem >= half) q = q + 1;
    if (q >= (64'd1 << (mw + 1))) begin q = q >> 1; e = e + 1; end
    if (e >= longint'(emax)) begin
      r.c = ones; r.ovf = 1'b1;
    end else if (e <= 0) begin
      r.c = 64'(s) << (w - 1); r.unf = 1'b1;
    end else begin
      r.c = (64'(s) << (w - 1)) | (64'(e) << mw) | (q & ((64'd1 << mw) - 1));
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  function automatic logic [31:0] rand_op();
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    s = 1'($urandom);
    f = 23'($urandom);
    case ($urandom % 8)
      0: return $urandom;
      1: e = 8'h00;
      2: e = 8'hFF;
      3: e = 8'(190 + $urandom % 65);
      4: e = 8'(1 + $urandom % 70);
      5: begin e = 8'(110 + $urandom % 40); f = {3'($urandom), 20'd0}; end
      default: e = 8'(100 + $urandom % 56);
    endcase
    return {s, e, f};
  endfunction

  // Scoreboard on the single-precision instance.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected actual=%h required=no_output", c);
        end else begin
          mres = exp_q.pop_front();
          check("mon_c", 64'(c), mres.c);
          check("mon_flags", 64'({inv, ovf, unf}), 64'({mres.inv, mres.ovf, mres.unf}));
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(ref_mul(64'(a), 64'(b), 8, 23, rnd_mode));
    end
  end

  task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic rm);
    in_valid = 1'b1; a = xa; b = xb; rnd_mode = rm;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_cyc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    timeout("send_accept");
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; return; end
    end
    timeout("wait_out_valid");
  endtask

  task automatic run16(input logic [15:0] xa, input logic [15:0] xb, input logic rm,
                       input logic [15:0] rc, input logic [2:0] rfl, input string name);
    bit got;
    iv16 = 1'b1; a16 = xa; b16 = xb; rm16 = rm;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (ir16) got = 1'b1;
    end
    @(posedge clk); #1;
    iv16 = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (ov16) got = 1'b1;
    end
    if (!got) timeout({name, "_wait"});
    else begin
      check({name, "_c"}, 64'(c16), 64'(rc));
      check({name, "_flags"}, 64'({inv16, ovf16, unf16}), 64'(rfl));
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        rm;
    logic [31:0] c;
    logic [2:0]  fl;   // {inv, ovf, unf}
  } vec_t;

  vec_t vecs[10];

  initial begin
    bit ok;
    int acc, k, nb, seen;
    logic [31:0] ba[5], bb[5];
    res_t r16;
    logic [15:0] ra16, rb16;

    vecs[0] = '{32'h40000000, 32'h40400000, 1'b0, 32'h40C00000, 3'b000};
    vecs[1] = '{32'hC0000000, 32'h40400000, 1'b0, 32'hC0C00000, 3'b000};
    vecs[2] = '{32'h3F800003, 32'h3FC00000, 1'b0, 32'h3FC00005, 3'b000};
    vecs[3] = '{32'h3F800003, 32'h3FC00000, 1'b1, 32'h3FC00004, 3'b000};
    vecs[4] = '{32'h7F000000, 32'h7F000000, 1'b0, 32'hFFFFFFFF, 3'b010};
    vecs[5] = '{32'h00800000, 32'h00800000, 1'b0, 32'h00000000, 3'b001};
    vecs[6] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'hFFFFFFFF, 3'b100};
    vecs[7] = '{32'h00000000, 32'h40000000, 1'b0, 32'h00000000, 3'b000};
    vecs[8] = '{32'h80000000, 32'h40000000, 1'b0, 32'h80000000, 3'b000};
    vecs[9] = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h3F800000, 3'b000};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; rnd_mode = 1'b0; a = '0; b = '0;
    iv16 = 1'b0; or16 = 1'b1; rm16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_c", 64'(c), 64'd0);
    check("rst_flags", 64'({inv, ovf, unf}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].rm);
      wait_out(ok);
      if (ok) begin
        if (i == 0) check("latency", 64'(cyc - acc_cyc), 64'd3);
        check($sformatf("vec%0d_c", i), 64'(c), 64'(vecs[i].c));
        check($sformatf("vec%0d_flags", i), 64'({inv, ovf, unf}), 64'(vecs[i].fl));
      end
      @(posedge clk); #1;
    end

    // Tie pair issued back to back must emerge on consecutive cycles.
    send(32'h3F800003, 32'h3FC00000, 1'b0);
    send(32'h3F800003, 32'h3FC00000, 1'b1);
    wait_out(ok);
    if (ok) begin
      check("b2b_first_c", 64'(c), 64'h3FC00005);
      @(negedge clk);
      check("b2b_second_valid", 64'(out_valid), 64'd1);
      check("b2b_second_c", 64'(c), 64'h3FC00004);
    end
    @(posedge clk); #1;

    // Backpressure: only three pairs fit while the output is blocked.
    for (int i = 0; i < 5; i++) begin ba[i] = rand_op(); bb[i] = rand_op(); end
    nb = n_out;
    out_ready = 1'b0;
    acc = 0; k = 0;
    in_valid = 1'b1; a = ba[0]; b = bb[0]; rnd_mode = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (in_ready && in_valid) begin
        acc++;
        @(posedge clk); #1;
        k++;
        if (k < 5) begin a = ba[k]; b = bb[k]; end
        else in_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    check("bp_accepted", 64'(acc), 64'd3);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_out_valid_held", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    for (int j = 3; j < 5; j++) send(ba[j], bb[j], 1'b0);
    repeat (8) @(posedge clk);
    #1;
    check("bp_delivered", 64'(n_out - nb), 64'd5);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset with two results in flight: neither may surface.
    nb = n_out;
    send(32'h40000000, 32'h40400000, 1'b0);
    send(32'h40400000, 32'h40400000, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_c", 64'(c), 64'd0);
    check("mrst_flags", 64'({inv, ovf, unf}), 64'd0);
    reset = 1'b0;
    check("mrst_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mrst_no_ghost", 64'(seen), 64'd0);
    check("mrst_no_delivery", 64'(n_out - nb), 64'd0);
    @(posedge clk); #1;

    // Randomized traffic with random stalls.
    for (int t = 0; t < 1500; t++) begin
      in_valid  = ($urandom % 4) != 0;
      a         = rand_op();
      b         = rand_op();
      rnd_mode  = 1'($urandom);
      out_ready = ($urandom % 4) != 0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    // Half-precision-like instance.
    run16(16'h4000, 16'h4200, 1'b0, 16'h4600, 3'b000, "h_mul");
    run16(16'h7800, 16'h7800, 1'b0, 16'hFFFF, 3'b010, "h_ovf");
    for (int i = 0; i < 30; i++) begin
      ra16 = 16'($urandom);
      rb16 = 16'($urandom);
      r16  = ref_mul(64'(ra16), 64'(rb16), 5, 10, 1'(i));
      run16(ra16, rb16, 1'(i), r16.c[15:0], {r16.inv, r16.ovf, r16.unf}, "h_rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

endmodule
